fetch_pc_sequencer: RTL and testbench
=====================================

# fetch_pc_sequencer

Fetch-side PC sequencer and redirect arbiter for the PQR5 core. It owns the fetch PC register and chooses each cycle between three sources, in priority order: execute-stage misprediction redirect, static branch predictor redirect, and sequential PC+4. It issues instruction-memory requests through a credit-limited handshake and tracks in-flight requests so stale responses after a redirect are marked for discard.

## Interface
- `PC_INIT`, default 32'h0000_0000: PC after reset.
- `MAX_OUTSTD`, default 2: maximum unanswered imem requests (1..7).
- `clk`  in  1  clock
- `aresetn`  in  1  reset, asynchronous, active-low
- `i_stall`  in  1  downstream stall; no new requests issued
- `i_exu_redir_valid`  in  1  misprediction redirect from EXU
- `i_exu_redir_pc`  in  `XLEN`  EXU redirect target
- `i_bp_flush`  in  1  predictor taken-pulse (one cycle)
- `i_bp_pc`  in  `XLEN`  predictor target, valid with `i_bp_flush`
- `o_imem_req`  out  1  request valid
- `o_imem_pc`  out  `XLEN`  request address
- `i_imem_ack`  in  1  request accepted this cycle
- `i_imem_rsp_valid`  in  1  response returned this cycle
- `o_rsp_drop`  out  1  current response is stale; FU must discard
- `o_fu_flush`  out  1  one-cycle pipeline flush on EXU redirect
- `o_bp_kill`  out  1  predictor pulse ignored due to same-cycle EXU redirect
- `o_mispred_cnt`  out  32  EXU redirect count (see Configuration)

## Operation
- States: BOOT (one cycle after reset, no request), RUN, HOLD (`i_stall`=1).
- BOOT -> RUN unconditionally. RUN -> HOLD when `i_stall`=1. HOLD -> RUN when `i_stall`=0.
- Next-PC priority: EXU redirect > `i_bp_flush` > (`i_imem_ack` ? pc+4 : pc). Redirects are accepted in any state except BOOT, including HOLD.
- `o_bp_kill`=1 when `i_exu_redir_valid` and `i_bp_flush` coincide; bp target discarded.
- `o_imem_req` = (state==RUN) && !`i_stall` && (outstd < `MAX_OUTSTD` || `i_imem_rsp_valid`).
- Outstanding count `outstd`: +1 on ack, -1 on rsp, unchanged on both together.
- Drop count `drop`: on any redirect, `drop` <= outstd + ack - rsp (includes the request acked in the redirect cycle). Otherwise it decrements on each rsp while nonzero.
- `o_rsp_drop` = `i_imem_rsp_valid` && (`drop` != 0), evaluated on the registered `drop`.
- A pending, unaccepted request may change address on redirect. imem samples address only on ack.
- Arithmetic is `XLEN`-bit modulo. pc+4 wraps at 2^XLEN silently. Bits [1:0] of redirect targets are forced to 0.
- A response arriving with outstd==0 is a protocol error. It is ignored and the counts hold.

## Timing
- Reset values: `o_imem_req`=0, `o_imem_pc`=`PC_INIT`, `o_rsp_drop`=0, `o_fu_flush`=0, `o_bp_kill`=0, `o_mispred_cnt`=0. outstd=0, drop=0, state=BOOT.
- First request is asserted on the 2nd rising edge after reset release.
- Redirect in cycle N -> `o_imem_pc`=target at N+1.
- `o_fu_flush` is registered, high at N+1 for exactly one cycle. Back-to-back EXU redirects give back-to-back flushes.
- `o_imem_pc` is registered. `o_imem_req`, `o_rsp_drop` and `o_bp_kill` are combinational from registers and inputs.
- Reset mid-operation clears all counts. Responses after reset are treated per the outstd==0 rule.

## Configuration
- `PQR5_MISPRED_STATS_EN` defined: a 32-bit wrapping counter increments on each cycle with `i_exu_redir_valid`=1 and drives `o_mispred_cnt`.
- Undefined: the counter is not built and `o_mispred_cnt` is tied to 0. Port list unchanged.

## Structure
- Package `pqr5_fetch_pkg`: state enum `fseq_state_t` {BOOT, RUN, HOLD}, constant `PC_INC`=4, and the outstd/drop counter width `OUTSTD_W`=3.
- `XLEN` is taken from `pqr5_core_macros.svh`.
- Sub-module `redir_stats_counter` holds the macro-guarded counter. The rest stays flat.

## Test plan
- Reset release, ack every cycle -> `o_imem_pc` = 0, 4, 8, … with the first request on edge 2.
- `MAX_OUTSTD`=2, no responses -> exactly 2 acks, then `o_imem_req`=0 until a response arrives.
- 2 outstanding, EXU redirect to 0x100 -> `o_fu_flush` pulses once. The next 2 responses have `o_rsp_drop`=1, the 3rd has 0. `o_imem_pc`=0x100.
- EXU redirect 0x200 and `i_bp_flush` 0x80 in the same cycle -> `o_bp_kill`=1, `o_imem_pc`=0x200.
- `i_stall`=1 with bp pulse to 0x40 -> `o_imem_req`=0 and `o_imem_pc`=0x40. After the stall drops, the request issues at 0x40.
- pc=0xFFFF_FFFC acked -> next `o_imem_pc`=0. With the macro on, 3 redirects -> `o_mispred_cnt`=3; with it off, 0.

Source files
------------

// File: rtl/pqr5_fetch_pkg.sv
// Shared types and constants for the PQR5 fetch PC sequencer.
// XLEN normally comes from pqr5_core_macros.svh; a 32-bit fallback keeps standalone builds working.
`ifndef XLEN
`define XLEN 32
`endif

package pqr5_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fseq_state_t;

  localparam int unsigned PC_INC   = 4;
  localparam int unsigned OUTSTD_W = 3;

endpackage

// File: rtl/redir_stats_counter.sv
// Misprediction statistics counter; built only when PQR5_MISPRED_STATS_EN is defined,
// otherwise the count output is tied to zero.
module redir_stats_counter (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        inc,
  output logic [31:0] cnt
);

`ifdef PQR5_MISPRED_STATS_EN
  logic [31:0] cnt_q;

  // Wraps silently at 2^32.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign cnt = cnt_q;
`else
  logic unused_stats;
  assign unused_stats = &{1'b0, clk, aresetn, inc};
  assign cnt = '0;
`endif

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC register, redirect arbitration and credit-limited imem request tracking.
// Optional misprediction counter is enabled with PQR5_MISPRED_STATS_EN.
`ifndef XLEN
`define XLEN 32
`endif

module fetch_pc_sequencer
  import pqr5_fetch_pkg::*;
#(
  parameter logic [`XLEN-1:0] PC_INIT    = '0,
  parameter int unsigned      MAX_OUTSTD = 2
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              i_stall,
  input  logic              i_exu_redir_valid,
  input  logic [`XLEN-1:0]  i_exu_redir_pc,
  input  logic              i_bp_flush,
  input  logic [`XLEN-1:0]  i_bp_pc,
  output logic              o_imem_req,
  output logic [`XLEN-1:0]  o_imem_pc,
  input  logic              i_imem_ack,
  input  logic              i_imem_rsp_valid,
  output logic              o_rsp_drop,
  output logic              o_fu_flush,
  output logic              o_bp_kill,
  output logic [31:0]       o_mispred_cnt
);

  localparam logic [OUTSTD_W-1:0] MAX_O = OUTSTD_W'(MAX_OUTSTD);

  fseq_state_t           state_q, state_d;
  logic [`XLEN-1:0]      pc_q, pc_d;
  logic [OUTSTD_W-1:0]   outstd_q, outstd_d;
  logic [OUTSTD_W-1:0]   drop_q, drop_d;
  logic                  fu_flush_q;

  logic                  redir_ok;
  logic                  exu_take;
  logic                  bp_take;
  logic                  ack_take;
  logic                  rsp_take;

  logic unused_lsb;
  assign unused_lsb = &{1'b0, i_exu_redir_pc[1:0], i_bp_pc[1:0]};

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= BOOT;
      pc_q       <= PC_INIT;
      outstd_q   <= '0;
      drop_q     <= '0;
      fu_flush_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      outstd_q   <= outstd_d;
      drop_q     <= drop_d;
      fu_flush_q <= exu_take;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    outstd_d   = outstd_q;
    drop_d     = drop_q;
    redir_ok   = (state_q != BOOT);
    exu_take   = redir_ok && i_exu_redir_valid;
    bp_take    = redir_ok && i_bp_flush && !i_exu_redir_valid;
    o_bp_kill  = redir_ok && i_exu_redir_valid && i_bp_flush;
    o_imem_req = (state_q == RUN) && !i_stall &&
                 ((outstd_q < MAX_O) || i_imem_rsp_valid);
    ack_take   = o_imem_req && i_imem_ack;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_take   = i_imem_rsp_valid && (outstd_q != '0);
    o_rsp_drop = i_imem_rsp_valid && (drop_q != '0);

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = i_stall ? HOLD : RUN;
      HOLD:    state_d = i_stall ? HOLD : RUN;
      default: state_d = BOOT;
    endcase

    case ({ack_take, rsp_take})
      2'b10:   outstd_d = outstd_q + OUTSTD_W'(1);
      2'b01:   outstd_d = outstd_q - OUTSTD_W'(1);
      default: outstd_d = outstd_q;
    endcase

    // Everything still in flight after this edge, including a same-cycle ack, is stale.
    if (exu_take || bp_take) begin
      drop_d = outstd_d;
    end else if (rsp_take && (drop_q != '0)) begin
      drop_d = drop_q - OUTSTD_W'(1);
    end

    if (exu_take) begin
      pc_d = {i_exu_redir_pc[`XLEN-1:2], 2'b00};
    end else if (bp_take) begin
      pc_d = {i_bp_pc[`XLEN-1:2], 2'b00};
    end else if (ack_take) begin
      pc_d = pc_q + `XLEN'(PC_INC);
    end
  end

  assign o_imem_pc  = pc_q;
  assign o_fu_flush = fu_flush_q;

  redir_stats_counter u_redir_stats_counter (
    .clk     (clk),
    .aresetn (aresetn),
    .inc     (i_exu_redir_valid),
    .cnt     (o_mispred_cnt)
  );

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer with a queue-based model of in-flight requests.
`ifndef XLEN
`define XLEN 32
`endif

module tb_fetch_pc_sequencer;

  localparam int MAXO = 2;
  localparam logic [`XLEN-1:0] PCI = '0;
`ifdef PQR5_MISPRED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              aresetn;
  logic              i_stall, i_exu_redir_valid, i_bp_flush, i_imem_ack, i_imem_rsp_valid;
  logic [`XLEN-1:0]  i_exu_redir_pc, i_bp_pc;
  logic              o_imem_req, o_rsp_drop, o_fu_flush, o_bp_kill;
  logic [`XLEN-1:0]  o_imem_pc;
  logic [31:0]       o_mispred_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_pc_sequencer #(.PC_INIT(PCI), .MAX_OUTSTD(MAXO)) dut (
    .clk               (clk),
    .aresetn           (aresetn),
    .i_stall           (i_stall),
    .i_exu_redir_valid (i_exu_redir_valid),
    .i_exu_redir_pc    (i_exu_redir_pc),
    .i_bp_flush        (i_bp_flush),
    .i_bp_pc           (i_bp_pc),
    .o_imem_req        (o_imem_req),
    .o_imem_pc         (o_imem_pc),
    .i_imem_ack        (i_imem_ack),
    .i_imem_rsp_valid  (i_imem_rsp_valid),
    .o_rsp_drop        (o_rsp_drop),
    .o_fu_flush        (o_fu_flush),
    .o_bp_kill         (o_bp_kill),
    .o_mispred_cnt     (o_mispred_cnt)
  );

  always #5 clk = ~clk;

  // Model: booted/held flags, the fetch PC, and a FIFO of in-flight requests tagged stale or live.
  logic [`XLEN-1:0] m_pc;
  bit               m_booted, m_hold, m_flush;
  bit               m_q[$];
  logic [31:0]      m_cnt;

  function automatic bit m_req();
    return m_booted && !m_hold && !i_stall && ((m_q.size() < MAXO) || i_imem_rsp_valid);
  endfunction

  function automatic bit m_drop();
    if (!i_imem_rsp_valid || m_q.size() == 0) return 1'b0;
    return m_q[0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_pc     = PCI;
      m_booted = 1'b0;
      m_hold   = 1'b0;
      m_flush  = 1'b0;
      m_cnt    = '0;
      m_q.delete();
    end else begin
      bit               acc, ackd, redir;
      logic [`XLEN-1:0] nxt;
      acc   = m_booted;
      ackd  = i_imem_ack && m_req();
      redir = acc && (i_exu_redir_valid || i_bp_flush);
      if (i_imem_rsp_valid && m_q.size() > 0) void'(m_q.pop_front());
      if (ackd) m_q.push_back(1'b0);
      if (redir) foreach (m_q[k]) m_q[k] = 1'b1;
      if (acc && i_exu_redir_valid)  nxt = i_exu_redir_pc & ~`XLEN'(3);
      else if (acc && i_bp_flush)    nxt = i_bp_pc & ~`XLEN'(3);
      else if (ackd)                 nxt = m_pc + `XLEN'(4);
      else                           nxt = m_pc;
      m_flush = acc && i_exu_redir_valid;
      if (i_exu_redir_valid) m_cnt = m_cnt + 32'd1;
      m_hold   = m_booted && i_stall;
      m_booted = 1'b1;
      m_pc     = nxt;
    end
  end

  always @(negedge clk) begin
    if (!aresetn) begin
      chk("rst_req",   o_imem_req,    0);
      chk("rst_pc",    o_imem_pc,     PCI);
      chk("rst_drop",  o_rsp_drop,    0);
      chk("rst_flush", o_fu_flush,    0);
      chk("rst_kill",  o_bp_kill,     0);
      chk("rst_cnt",   o_mispred_cnt, 0);
    end else begin
      chk("req",   o_imem_req, m_req());
      chk("pc",    o_imem_pc,  m_pc);
      chk("drop",  o_rsp_drop, m_drop());
      chk("flush", o_fu_flush, m_flush);
      chk("kill",  o_bp_kill,  m_booted && i_exu_redir_valid && i_bp_flush);
      chk("cnt",   o_mispred_cnt, STATS ? m_cnt : 32'd0);
    end
  end

  task automatic setin(input bit st, input bit ev, input logic [31:0] ep,
                       input bit bf, input logic [31:0] bpc, input bit ak, input bit rv);
    i_stall           = st;
    i_exu_redir_valid = ev;
    i_exu_redir_pc    = ep;
    i_bp_flush        = bf;
    i_bp_pc           = bpc;
    i_imem_ack        = ak;
    i_imem_rsp_valid  = rv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    aresetn = 1'b0;
    setin(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;

    // Boot cycle, then sequential fetch until credits run out
    #1 chk("boot_req", o_imem_req, 0);
    tick();
    setin(0, 0, 0, 0, 0, 1, 0);
    #1 chk("first_req", o_imem_req, 1);
    chk("first_pc", o_imem_pc, 32'h0);
    tick();
    chk("pc_seq4", o_imem_pc, 32'h4);
    tick();
    chk("pc_seq8", o_imem_pc, 32'h8);
    #1 chk("credit_block", o_imem_req, 0);
    tick();
    chk("pc_held", o_imem_pc, 32'h8);
    setin(0, 0, 0, 0, 0, 1, 1);
    #1 chk("rsp_frees_credit", o_imem_req, 1);
    tick();
    chk("pc_seqc", o_imem_pc, 32'hC);

    // EXU redirect with two outstanding
    setin(0, 1, 32'h100, 0, 0, 0, 0);
    tick();
    chk("redir_pc", o_imem_pc, 32'h100);
    chk("flush_on", o_fu_flush, 1);
    setin(0, 0, 0, 0, 0, 0, 1);
    #1 chk("drop_1st", o_rsp_drop, 1);
    tick();
    chk("flush_once", o_fu_flush, 0);
    #1 chk("drop_2nd", o_rsp_drop, 1);
    tick();
    setin(0, 0, 0, 0, 0, 1, 0);
    tick();
    chk("pc_104", o_imem_pc, 32'h104);
    setin(0, 0, 0, 0, 0, 0, 1);
    #1 chk("drop_3rd", o_rsp_drop, 0);
    tick();

    // Same-cycle EXU and predictor, then back-to-back EXU redirects
    setin(0, 1, 32'h200, 1, 32'h80, 0, 0);
    #1 chk("bp_kill", o_bp_kill, 1);
    tick();
    chk("exu_wins", o_imem_pc, 32'h200);
    setin(0, 1, 32'h300, 0, 0, 0, 0);
    tick();
    chk("b2b_flush", o_fu_flush, 1);
    chk("b2b_pc", o_imem_pc, 32'h300);
    setin(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("flush_off", o_fu_flush, 0);

    // Predictor redirect during stall
    setin(1, 0, 0, 1, 32'h40, 1, 0);
    #1 chk("stall_req", o_imem_req, 0);
    tick();
    chk("stall_bp_pc", o_imem_pc, 32'h40);
    setin(1, 0, 0, 0, 0, 1, 0);
    tick();
    setin(0, 0, 0, 0, 0, 1, 0);
    #1 chk("hold_req", o_imem_req, 0);
    tick();
    #1 chk("resume_req", o_imem_req, 1);
    chk("resume_pc", o_imem_pc, 32'h40);
    tick();
    chk("resume_next", o_imem_pc, 32'h44);

    // Wrap at top of address space; low target bits forced to zero
    setin(0, 0, 0, 1, 32'hFFFF_FFFE, 0, 0);
    tick();
    chk("top_pc", o_imem_pc, 32'hFFFF_FFFC);
    setin(0, 0, 0, 0, 0, 1, 1);
    #1 chk("drop_wrap", o_rsp_drop, 1);
    tick();
    chk("wrap_pc", o_imem_pc, 32'h0);
    setin(0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("mispred_cnt", o_mispred_cnt, STATS ? 32'd3 : 32'd0);

    // Reset mid-operation with requests in flight
    setin(0, 0, 0, 0, 0, 1, 0);
    tick();
    tick();
    setin(0, 1, 32'h500, 0, 0, 0, 0);
    tick();
    setin(0, 0, 0, 0, 0, 0, 0);
    aresetn = 1'b0;
    #1 chk("midrst_pc", o_imem_pc, PCI);
    repeat (2) tick();
    aresetn = 1'b1;
    setin(0, 0, 0, 0, 0, 0, 1);
    #1 chk("post_rst_drop", o_rsp_drop, 0);
    tick();
    setin(0, 0, 0, 0, 0, 1, 1);
    tick();
    chk("post_rst_pc", o_imem_pc, 32'h4);

    // Mixed traffic checked by the model
    for (int i = 0; i < 80; i++) begin
      setin($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, $urandom,
            $urandom_range(0, 5) == 0, $urandom,
            $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1);
      tick();
    end
    setin(0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
